// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencing and single-outstanding instruction fetch,
// handing fetched words to decode over valid/ready and squashing on redirect.
module fetch_controller #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] redirect_pc;
    logic        accept;

    assign redirect_pc    = redirect_addr & ~32'h3;
    assign imem_req_valid = rst && (state == FETCH);
    assign imem_req_addr  = pc;
    assign pc_out         = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_ADDR;
            req_pc     <= '0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
        end else if (redirect_valid) begin
            // Redirect wins; a response already owed becomes a DROP.
            pc         <= redirect_pc;
            inst_valid <= 1'b0;
            unique case (state)
                FETCH: state <= accept ? DROP : FETCH;
                WAIT:  state <= imem_rsp_valid ? FETCH : DROP;
                HOLD:  state <= FETCH;
                DROP:  state <= DROP;
                default: state <= FETCH;
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (accept) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        inst_data  <= imem_rsp_data;
                        inst_pc    <= req_pc;
                        inst_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: latency-programmable memory responder plus a
// scoreboard of expected (pc, data) pairs popped on each decode handshake.
module tb_fetch_controller;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] pc_out;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_inst_valid;
    logic [31:0] w_inst_data;
    logic [31:0] w_inst_pc;
    logic [31:0] w_pc_out;

    int          checks;
    int          errors;
    int          hs_count;
    int          mem_lat;
    logic [31:0] last_pc;
    logic [31:0] exp_pc;
    exp_t        sb[$];

    fetch_controller dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .inst_valid(inst_valid),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .pc_out(pc_out)
    );

    fetch_controller #(.RESET_ADDR(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .inst_valid(w_inst_valid),
        .inst_data(w_inst_data), .inst_pc(w_inst_pc),
        .inst_ready(inst_ready), .pc_out(w_pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    task automatic memory();
        logic [31:0] a;
        int          lat;
        forever begin
            @(negedge clk);
            if (rst && imem_req_valid && imem_req_ready) begin
                a   = imem_req_addr;
                lat = mem_lat;
                @(posedge clk);
                repeat (lat - 1) @(posedge clk);
                #1;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data(a);
                @(posedge clk);
                #1;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                exp_pc = 32'h0;
            end else begin
                if (inst_valid && inst_ready) begin
                    hs_count++;
                    last_pc = inst_pc;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_inst pc=%h data=%h, none expected",
                                 inst_pc, inst_data);
                    end else begin
                        e = sb.pop_front();
                        if (inst_pc !== e.pc || inst_data !== e.data) begin
                            errors++;
                            $display("FAIL inst got pc=%h data=%h want pc=%h data=%h",
                                     inst_pc, inst_data, e.pc, e.data);
                        end
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    checks++;
                    if (imem_req_addr !== exp_pc) begin
                        errors++;
                        $display("FAIL req_addr got %h want %h", imem_req_addr, exp_pc);
                    end
                    if (!redirect_valid) sb.push_back('{exp_pc, mem_data(exp_pc)});
                    exp_pc = exp_pc + 32'd4;
                end
                if (redirect_valid) begin
                    sb.delete();
                    exp_pc = redirect_addr & ~32'h3;
                end
            end
        end
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_hs(output bit ok);
        int h0;
        h0 = hs_count;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (hs_count != h0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        inst_ready     = 1'b1;
        mem_lat        = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_req_valid got %b want 0", imem_req_valid);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_inst_valid got %b want 0", inst_valid);
        end
        checks++;
        if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_inst got data=%h pc=%h want 0", inst_data, inst_pc);
        end
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL rst_pc_out got %h want 0", pc_out);
        end
    endtask

    task automatic test_stream();
        int h0;
        h0 = hs_count;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req got v=%b a=%h want v=1 a=0",
                     imem_req_valid, imem_req_addr);
        end
        repeat (11) @(negedge clk);
        #1;
        checks++;
        if (hs_count - h0 != 4) begin
            errors++;
            $display("FAIL stream_rate got %0d insts want 4 in 12 cycles", hs_count - h0);
        end
        checks++;
        if (pc_out !== 32'h10) begin
            errors++;
            $display("FAIL stream_pc_out got %h want 00000010", pc_out);
        end
    endtask

    task automatic test_stall();
        bit seen;
        @(posedge clk);
        #1 inst_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_timeout got no inst_valid want 1");
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h10 ||
                inst_data !== mem_data(32'h10) || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold got v=%b pc=%h d=%h rq=%b want 1/10/%h/0",
                         inst_valid, inst_pc, inst_data, imem_req_valid,
                         mem_data(32'h10));
            end
        end
        @(posedge clk);
        #1 inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h14) begin
            errors++;
            $display("FAIL stall_resume got v=%b a=%h want v=1 a=00000014",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        @(posedge clk);
        #1 mem_lat = 2;
        wait_accept(ok);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_1003;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_accept(ok);
        checks++;
        if (!ok || imem_req_addr !== 32'h1000) begin
            errors++;
            $display("FAIL redir_wait_req got ok=%b a=%h want 00001000",
                     ok, imem_req_addr);
        end
        wait_hs(ok);
        checks++;
        if (!ok || last_pc !== 32'h1000) begin
            errors++;
            $display("FAIL redir_wait_inst got ok=%b pc=%h want 00001000", ok, last_pc);
        end
        mem_lat = 1;
    endtask

    task automatic test_redirect_same_cycle();
        bit ok;
        wait_accept(ok);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_2000;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin
            errors++;
            $display("FAIL redir_rsp_req got v=%b a=%h want v=1 a=00002000",
                     imem_req_valid, imem_req_addr);
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_3000;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        @(negedge clk);
        checks++;
        if (!ok || inst_valid !== 1'b0 || imem_req_valid !== 1'b1 ||
            imem_req_addr !== 32'h3000) begin
            errors++;
            $display("FAIL redir_hold got ok=%b iv=%b rq=%b a=%h want 1/0/1/00003000",
                     ok, inst_valid, imem_req_valid, imem_req_addr);
        end
        wait_hs(ok);
        checks++;
        if (!ok || last_pc !== 32'h3000) begin
            errors++;
            $display("FAIL redir_hold_inst got ok=%b pc=%h want 00003000", ok, last_pc);
        end
        mem_lat = 3;
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_accept(ok);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_rst got iv=%b rq=%b pc=%h want 0/0/00000000",
                     inst_valid, imem_req_valid, pc_out);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 ||
                inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_stale got rq=%b a=%h iv=%b want 1/00000000/0",
                         imem_req_valid, imem_req_addr, inst_valid);
            end
        end
        @(posedge clk);
        #1;
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        wait_hs(ok);
        checks++;
        if (!ok || last_pc !== 32'h0) begin
            errors++;
            $display("FAIL mid_rst_first got ok=%b pc=%h want 00000000", ok, last_pc);
        end
    endtask

    task automatic test_wrap();
        bit          ok;
        logic [31:0] wexp[3];
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_accept(ok);
            checks++;
            if (!ok || w_req_valid !== 1'b1 || w_req_addr !== wexp[i]) begin
                errors++;
                $display("FAIL wrap_req%0d got ok=%b a=%h want %h",
                         i, ok, w_req_addr, wexp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (w_pc_out !== 32'h4) begin
            errors++;
            $display("FAIL wrap_pc_out got %h want 00000004", w_pc_out);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        hs_count = 0;
        last_pc  = '0;
        exp_pc   = '0;
        test_reset();
        fork
            memory();
            monitor();
        join_none
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_reset_mid();
        test_wrap();
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the program counter and instruction fetch for the core. It issues one instruction-memory read at a time from the current PC and advances the PC by 4 on each accepted request. It hands the returned instruction and its PC to decode over a valid/ready handshake. Branch/jump redirects reload the PC and discard any in-flight or held fetch.

## Interface
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; asynchronous and active-low (0 = reset asserted)
- imem_req_valid  out  1  read request to instruction memory
- imem_req_addr  out  32  request address (always word aligned)
- imem_req_ready  in  1  memory accepts request when high with imem_req_valid
- imem_rsp_valid  in  1  read data valid; in order, at most one outstanding, earliest 1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle pulse: change fetch stream
- redirect_addr  in  32  new PC; bits [1:0] ignored (forced to 0)
- inst_valid  out  1  instruction available to decode
- inst_data  out  32  instruction word
- inst_pc  out  32  address inst_data was fetched from
- inst_ready  in  1  decode accepts when high with inst_valid
- pc_out  out  32  next fetch address (architectural fetch PC)

## Operation
- States: FETCH, WAIT, HOLD, DROP. Internal regs: pc, req_pc, inst_data/inst_pc/inst_valid.
- imem_req_valid = (state == FETCH); imem_req_addr = pc_out = pc. All other outputs registered.
- FETCH: on imem_req_ready, req_pc <= pc, pc <= pc + 4, go to WAIT.
- WAIT: on imem_rsp_valid, inst_data <= imem_rsp_data, inst_pc <= req_pc, inst_valid <= 1, go to HOLD.
- HOLD: inst_valid = 1 and outputs stable. On inst_ready, inst_valid <= 0 and go to FETCH. inst_ready low (stall) holds indefinitely.
- DROP: no request. On imem_rsp_valid, discard the data and go to FETCH.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- A redirect_valid pulse has priority over all other transitions. It sets pc <= {redirect_addr[31:2], 2'b00} and inst_valid <= 0. The next state depends on the current state:
  - FETCH, request not accepted this cycle: stay in FETCH.
  - FETCH, request accepted this cycle: go to DROP.
  - WAIT, no response this cycle: go to DROP.
  - WAIT, response this cycle: discard the response, go to FETCH.
  - HOLD: go to FETCH. If inst_ready is also high, that transfer completes normally; otherwise the held instruction is discarded.
  - DROP: stay in DROP.
- A redirect never produces a duplicate or stale instruction on inst_*.
- imem_rsp_valid arriving in FETCH or HOLD is a protocol violation and is ignored.

## Timing
- While rst = 0:
  - state = FETCH, pc = RESET_ADDR.
  - inst_valid = 0, inst_data = 0, inst_pc = 0, req_pc = 0.
  - imem_req_valid forced to 0.
- First rising edge after rst goes high: imem_req_valid = 1 and imem_req_addr = RESET_ADDR are already presented in that cycle.
- Request accepted at edge N. Response earliest in cycle N+1. inst_valid high from the edge that samples the response.
- Best-case throughput is 1 instruction per 3 cycles (FETCH, WAIT, HOLD), with single-cycle memory and inst_ready tied high.
- pc_out updates on the edge after acceptance or redirect.
- Reset asserted mid-operation: all state returns to reset values immediately. A response arriving after reset release while in FETCH is ignored.

## Test plan
- Reset, memory always ready with 1-cycle latency, inst_ready = 1 -> inst_pc sequence 0x0, 0x4, 0x8, 0xC, one instruction every 3 cycles; inst_data matches memory.
- inst_ready held low 5 cycles in HOLD -> inst_valid, inst_data and inst_pc stable; no new imem request; fetch resumes the cycle after inst_ready rises.
- Redirect to 0x0000_1003 while in WAIT, response 2 cycles later -> response discarded; next request addr = 0x0000_1000; next inst_pc = 0x1000.
- Redirect in the same cycle as the response in WAIT, and redirect in HOLD with inst_ready = 0 -> no instruction delivered from the old stream; next request goes to the redirect target.
- RESET_ADDR = 32'hFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- rst pulsed low while in WAIT -> inst_valid drops immediately; after release the first request is RESET_ADDR; a late stale response is ignored.
